// File: rtl/wavelet_inv_lift.sv
// Inverse integer lifting stage: rebuilds even/odd pixel pairs from (L, H) coefficients
// and streams them out even-first, flagging the odd pixel that closes each line.
module wavelet_inv_lift #(
  parameter int W          = 8,
  parameter int LINE_PAIRS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_l,
  input  logic [W-1:0] in_h,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pix,
  output logic         out_last
);

  localparam int CW = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(LINE_PAIRS - 1);

  localparam logic [0:0] EVEN = 1'b0;
  localparam logic [0:0] ODD  = 1'b1;

  logic          s1Valid_q, s1Valid_d;
  logic [W-1:0]  o1_q, o1_d;
  logic [W-1:0]  h1_q, h1_d;
  logic          s2Valid_q, s2Valid_d;
  logic [W-1:0]  e2_q, e2_d;
  logic [W-1:0]  o2_q, o2_d;
  logic [0:0]    phase_q, phase_d;
  logic [CW-1:0] pairCnt_q, pairCnt_d;

  logic outXfer;
  logic oddXfer;
  logic s1Adv;
  logic inXfer;

  assign outXfer  = s2Valid_q && out_ready;
  assign oddXfer  = outXfer && (phase_q == ODD);
  assign s1Adv    = s1Valid_q && (!s2Valid_q || ((phase_q == ODD) && out_ready));
  assign in_ready = !s1Valid_q || s1Adv;
  assign inXfer   = in_valid && in_ready;

  assign out_valid = s2Valid_q;
  assign out_pix   = (phase_q == ODD) ? o2_q : e2_q;
  assign out_last  = (phase_q == ODD) && (pairCnt_q == LAST_PAIR);

  // Undo the forward steps in reverse order; all arithmetic wraps at W bits.
  always_comb begin
    s1Valid_d = s1Valid_q;
    o1_d      = o1_q;
    h1_d      = h1_q;
    if (s1Adv) s1Valid_d = 1'b0;
    if (inXfer) begin
      s1Valid_d = 1'b1;
      o1_d      = in_l - (in_h >> 2);
      h1_d      = in_h;
    end
  end

  // A pair moving in from s1 takes priority so s2 reloads on the odd transfer without a bubble.
  always_comb begin
    s2Valid_d = s2Valid_q;
    e2_d      = e2_q;
    o2_d      = o2_q;
    phase_d   = phase_q;
    pairCnt_d = pairCnt_q;
    if (s1Adv) begin
      s2Valid_d = 1'b1;
      e2_d      = h1_q + (o1_q >> 1);
      o2_d      = o1_q;
      phase_d   = EVEN;
    end else if (oddXfer) begin
      s2Valid_d = 1'b0;
      phase_d   = EVEN;
    end else if (outXfer) begin
      phase_d   = ODD;
    end
    if (oddXfer) begin
      pairCnt_d = (pairCnt_q == LAST_PAIR) ? '0 : pairCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      o1_q      <= '0;
      h1_q      <= '0;
      s2Valid_q <= 1'b0;
      e2_q      <= '0;
      o2_q      <= '0;
      phase_q   <= EVEN;
      pairCnt_q <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      o1_q      <= o1_d;
      h1_q      <= h1_d;
      s2Valid_q <= s2Valid_d;
      e2_q      <= e2_d;
      o2_q      <= o2_d;
      phase_q   <= phase_d;
      pairCnt_q <= pairCnt_d;
    end
  end

endmodule

// File: tb/tb_wavelet_inv_lift.sv
// Directed bench for wavelet_inv_lift: a scoreboard queue holds the expected pixel
// stream (with line-end flags), and a negedge monitor pops it on every output transfer.
module tb_wavelet_inv_lift;

  localparam int W  = 8;
  localparam int LP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_l;
  logic [W-1:0] in_h;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_pix;
  logic         out_last;

  wavelet_inv_lift #(.W(W), .LINE_PAIRS(LP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_l     (in_l),
    .in_h     (in_h),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int modelPairs = 0;
  int validCount = 0;
  int lastCount  = 0;
  int firstValid = -1;
  int lastValid  = -1;
  logic [W:0] sb[$];
  int acceptCyc[$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      validCount++;
      if (firstValid < 0) firstValid = cyc;
      lastValid = cyc;
      if (out_ready) begin
        if (out_last) lastCount++;
        if (sb.size() == 0) begin
          checkOutput("spurious_out", sb.size(), 1);
        end else begin
          logic [W:0] exp;
          exp = sb.pop_front();
          checkOutput("pix", out_pix, exp[W-1:0]);
          checkOutput("last", out_last, exp[W]);
        end
      end
    end
  end

  // Drive one pair, wait (bounded) for acceptance, then record the expected pixels.
  task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] h);
    logic acc;
    logic [W-1:0] o;
    logic [W-1:0] e;
    int n;
    in_l = l;
    in_h = h;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checkOutput("accept_timeout", acc, 1);
    end else begin
      acceptCyc.push_back(cyc);
      o = l - (h >> 2);
      e = h + (o >> 1);
      sb.push_back({1'b0, e});
      sb.push_back({(modelPairs % LP) == (LP - 1), o});
      modelPairs++;
    end
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    modelPairs = 0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gapBad;
    rst = 1'b1;
    in_valid = 1'b0;
    in_l = '0;
    in_h = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_pix", out_pix, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    #5;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic reconstruction and latency
    applyStimulus(8'd85, 8'd117);
    in_valid = 1'b0;
    checkOutput("lat_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_even_pix", out_pix, 145);
    waitDrain(20);

    // Wrap-around arithmetic
    applyStimulus(8'd241, 8'd166);
    applyStimulus(8'd90, 8'd5);
    in_valid = 1'b0;
    waitDrain(20);

    // Backpressure with both stages full
    out_ready = 1'b0;
    applyStimulus(8'd85, 8'd117);
    applyStimulus(8'd241, 8'd166);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_pix", out_pix, 145);
      checkOutput("bp_last", out_last, 0);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain(20);

    // Streaming throughput and line markers from a clean counter
    pulseReset();
    validCount = 0;
    lastCount = 0;
    firstValid = -1;
    lastValid = -1;
    acceptCyc.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end
    in_valid = 1'b0;
    waitDrain(100);
    checkOutput("stream_valid_cycles", validCount, 32);
    checkOutput("stream_span", lastValid - firstValid + 1, 32);
    checkOutput("stream_last_count", lastCount, 4);
    gapBad = 0;
    for (int i = 2; i < acceptCyc.size(); i++) begin
      if (acceptCyc[i] - acceptCyc[i-1] != 2) gapBad++;
    end
    checkOutput("stream_accept_count", acceptCyc.size(), 16);
    checkOutput("stream_in_ready_alt", gapBad, 0);

    // Asynchronous reset while s2 presents the odd pixel
    out_ready = 1'b0;
    applyStimulus(8'd85, 8'd117);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("pre_rst_valid", out_valid, 1);
    checkOutput("pre_rst_odd_pix", out_pix, 56);
    #3;
    rst = 1'b1;
    sb.delete();
    modelPairs = 0;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_pix", out_pix, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    lastCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'd85, 8'd117);
    in_valid = 1'b0;
    waitDrain(40);
    checkOutput("post_rst_last_count", lastCount, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wavelet_inv_lift.md
# wavelet_inv_lift

- Inverse integer lifting stage of the image-squash datapath.
- Accepts a stream of (L, H) coefficient pairs, i.e. one low-band and one high-band coefficient per pair, and reconstructs the original even/odd pixel pair exactly.
- Emits the reconstructed pixels serially, even pixel first then odd, with a line-end marker.
- Sits at the decompression end, mirroring the forward lifting transform.
- Forward transform, modulo 2^W: H = e − (o >> 1), then L = o + (H >> 2).

## Interface

Parameters:
- W, 8, sample and coefficient width.
- LINE_PAIRS, 32, coefficient pairs per image line; must be ≥ 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset: asynchronous, active-high.
- in_valid, input, 1, in_l/in_h hold a valid pair.
- in_ready, output, 1, block accepts a pair this cycle.
- in_l, input, W, low-band coefficient L.
- in_h, input, W, high-band coefficient H.
- out_valid, output, 1, out_pix holds a valid pixel.
- out_ready, input, 1, downstream accepts the pixel.
- out_pix, output, W, reconstructed pixel.
- out_last, output, 1, asserted with the odd pixel of the last pair of a line.

## Operation

Handshake:
- A transfer occurs on any rising edge where valid && ready.
- Input is accepted only on in_valid && in_ready.
- in_l and in_h are sampled on that edge.

Stage 1 (s1), loads on input accept:
- o1 = in_l − (in_h >> 1 >> 1), i.e. in_l − (in_h >> 2), mod 2^W.
- h1 = in_h.
- s1_valid = 1.

Stage 2 (s2, the output pair register), loads from s1 when s1 advances:
- e2 = h1 + (o1 >> 1), mod 2^W.
- o2 = o1.
- s2_valid = 1.
- phase = EVEN.

Arithmetic rules:
- All shifts are logical, on unsigned W-bit values.
- Sums and differences wrap modulo 2^W with no saturation, so reconstruction is exact for every input.

Serializer FSM, states EVEN and ODD:
- EVEN: out_pix = e2, out_last = 0. On out_ready, go to ODD.
- ODD: out_pix = o2, out_last = (pair_cnt == LINE_PAIRS−1). On out_ready, go to EVEN and free s2.
- out_valid = s2_valid.

Flow control:
- s1 advances when s1_valid && (!s2_valid || (phase==ODD && out_ready)).
- in_ready = !s1_valid || s1_adv (combinational).
- A new pair may enter s1 on the same edge s1 empties into s2.

Pair counter:
- pair_cnt increments on each ODD-phase transfer.
- It wraps to 0 after LINE_PAIRS−1; out_last marks that wrapping transfer.

Boundary conditions:
- Simultaneous s2 release and s1 advance: s2 reloads directly, with no bubble.
- Backpressure: while out_valid && !out_ready, out_pix, out_last and phase hold stable.
- in_valid low: the pipeline drains normally; no spurious out_valid.

Reset:
- Asserting rst immediately clears s1_valid, s2_valid, phase=EVEN, pair_cnt=0, and all data registers to 0.
- Any in-flight pair is discarded.
- Reset values of outputs: out_valid=0, out_pix=0, out_last=0, in_ready=1 (after reset, since s1 is empty).

## Timing

- Latency:
  - Pair accepted at edge k loads s1.
  - Edge k+1 loads s2.
  - The even pixel is presented (out_valid=1) in the cycle following edge k+1.
  - The odd pixel follows after the next accepted output transfer.
- Throughput:
  - 1 pixel per clock with out_ready held high.
  - in_ready is high every other cycle in steady state.
- No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready.

## Test plan

- Basic reconstruction: reset, then in (L=85, H=117) with out_ready=1 → out_pix 145 then 56; out_valid first high one cycle after acceptance.
- Wrap-around arithmetic: in (L=241, H=166) → out 10 then 200; then in (L=90, H=5) → out 49 then 89.
- Backpressure: hold out_ready=0 for 5 cycles with the first pixel presented.
  - Required: out_pix stays 145 and in_ready falls once s1 is full.
  - After release: exact order 145, 56, next pair; no loss or duplication.
- Line marker: LINE_PAIRS=4, stream 8 pairs with out_ready=1.
  - out_last is high only on the odd pixel of pairs 4 and 8, i.e. pixel outputs 8 and 16.
  - pair_cnt wraps to 0.
- Streaming throughput: 16 back-to-back pairs with in_valid=1 and out_ready=1 → 32 consecutive out_valid cycles with no bubbles; in_ready alternates.
- Reset mid-operation: assert rst asynchronously between clock edges while s2 is in ODD.
  - out_valid drops immediately.
  - After release, pair (L=85, H=117) yields 145 then 56, with out_last/pair_cnt counting from 0.
